// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data memory controller.
//   - size encodings for byte / halfword / word accesses
//   - FSM state enum
//   - wait-counter width (supports WAIT_CYCLES 0..15)
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for the data memory.
//   old_word  in  32  current contents of the addressed word
//   wdata     in  32  right-justified store data
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset    in  2   byte offset within the word (addr[1:0])
//   is_signed in  1   sign-extend sub-word loads
//   new_word  out 32  old_word with the addressed lane(s) replaced
//   rdata     out 32  addressed lane, zero- or sign-extended
// Alignment is not checked here; the caller gates writes on errors.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        new_word = old_word;
        case (size)
            SZ_BYTE: new_word[{offset, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: new_word[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
            SZ_WORD: new_word                               = wdata;
            default: new_word                               = old_word;
        endcase
    end

    always_comb begin
        sel_byte = old_word[{offset, 3'b000} +: 8];
        sel_half = old_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: rdata = {{24{is_signed & sel_byte[7]}}, sel_byte};
            SZ_HALF: rdata = {{16{is_signed & sel_half[15]}}, sel_half};
            SZ_WORD: rdata = old_word;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory for the MIPS memory stage. One load/store per
// valid/ready handshake, completed WAIT_CYCLES+1 edges after acceptance.
//   clk, reset (async active-low)
//   req_valid/req_ready  request handshake
//   req_we, req_size, req_signed, req_addr, req_wdata, req_pc  request fields
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   load data / error flag, held until next completion
// Optional: define DM_TRACE_EN to print every completed non-error store.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_signed;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        cur_word;
    logic [31:0]        new_word;
    logic [31:0]        ld_data;
    logic               acc_err;
    logic               finish;
    logic               mem_we;

    assign req_ready = (state == IDLE);
    assign word_idx  = lat_addr[ADDR_W+1:2];
    assign cur_word  = mem[word_idx];
    assign finish    = (state == BUSY) && (cnt == '0);
    // state is cleared asynchronously, so a reset during BUSY kills the write
    assign mem_we    = finish && lat_we && !acc_err;

    always_comb begin
        acc_err = 1'b0;
        if (lat_size == 2'b11)                               acc_err = 1'b1;
        if (lat_size == SZ_HALF && lat_addr[0])              acc_err = 1'b1;
        if (lat_size == SZ_WORD && lat_addr[1:0] != 2'b00)   acc_err = 1'b1;
        if ((lat_addr >> (ADDR_W + 2)) != 32'd0)             acc_err = 1'b1;
    end

    dm_lane_align u_align (
        .old_word  (cur_word),
        .wdata     (lat_wdata),
        .size      (lat_size),
        .offset    (lat_addr[1:0]),
        .is_signed (lat_signed),
        .new_word  (new_word),
        .rdata     (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= SZ_WORD;
            lat_signed <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        cnt        <= CNT_W'(WAIT_CYCLES);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_we) ? 32'd0 : ld_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] lat_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lat_pc <= 32'd0;
        else if (req_valid && req_ready)
            lat_pc <= req_pc;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= new_word;
            $display("%d@%h: *%h <= %h", $time, lat_pc, {lat_addr[31:2], 2'b00}, new_word);
        end
    end
`else
    // pc only feeds the trace
    logic unused_pc;
    assign unused_pc = ^req_pc;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_idx] <= new_word;
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sgn = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] pc = 32'h0040_0000;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_err, b_err;
    logic [31:0] a_rdata, b_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr),
        .req_wdata(wdata), .req_pc(pc), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr),
        .req_wdata(wdata), .req_pc(pc), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    // Issue one request to dut_a (sel_b=0) or dut_b (sel_b=1) and wait for
    // its response; lat = edges from accept to rsp_valid (capped at 40).
    task automatic issue(input bit sel_b, input bit w, input logic [1:0] sz,
                         input bit sg, input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        we = w; size = sz; sgn = sg; addr = ad; wdata = wd; pc = pc + 32'd4;
        if (sel_b) b_valid = 1'b1; else a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        lat = 0;
        while (!(sel_b ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel_b ? b_rdata : a_rdata;
        er = sel_b ? b_err : a_err;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rdata !== 32'd0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", a_ready, a_rsp_valid, a_rdata, a_err);
        end
        checks++;
        if (b_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rdata !== 32'd0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", b_ready, b_rsp_valid, b_rdata, b_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        issue(0, 1, 2'b10, 0, 32'h10, 32'h1234_5678, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sw_word got lat=%0d err=%b rd=%h exp 1 0 00000000", lat, er, rd);
        end
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lw_word got lat=%0d err=%b rd=%h exp 1 0 12345678", lat, er, rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        issue(0, 1, 2'b00, 0, 32'h13, 32'hFFFF_FFAB, rd, er, lat);
        issue(0, 0, 2'b00, 1, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_FFAB || er !== 1'b0) begin
            errors++;
            $display("FAIL lb_signed got %h err=%b exp ffffffab 0", rd, er);
        end
        issue(0, 0, 2'b00, 0, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_00AB) begin
            errors++;
            $display("FAIL lbu got %h exp 000000ab", rd);
        end
        issue(0, 0, 2'b00, 1, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_0078) begin
            errors++;
            $display("FAIL lb_pos got %h exp 00000078", rd);
        end
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hAB34_5678) begin
            errors++;
            $display("FAIL sb_merge got %h exp ab345678", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        issue(0, 1, 2'b01, 0, 32'h12, 32'h5555_8001, rd, er, lat);
        issue(0, 0, 2'b01, 1, 32'h12, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin
            errors++;
            $display("FAIL lh got %h err=%b exp ffff8001 0", rd, er);
        end
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu got %h exp 00008001", rd);
        end
        issue(0, 0, 2'b10, 0, 32'h11, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d exp 1 00000000 1", er, rd, lat);
        end
        issue(0, 1, 2'b01, 0, 32'h13, 32'h0000_FFFF, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL sh_misaligned got err=%b exp 1", er);
        end
        issue(0, 1, 2'b11, 0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL size11 got err=%b exp 1", er);
        end
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h8001_5678 || er !== 1'b0) begin
            errors++;
            $display("FAIL half_merge got %h err=%b exp 80015678 0", rd, er);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat;
        issue(0, 1, 2'b10, 0, 32'h0, 32'hCAFE_F00D, rd, er, lat);
        issue(0, 1, 2'b10, 0, 32'h4000, 32'h1111_1111, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sw_out_of_range got err=%b rd=%h exp 1 00000000", er, rd);
        end
        issue(0, 0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_oor got %h err=%b exp cafef00d 0", rd, er);
        end
        issue(0, 1, 2'b00, 0, 32'h3FFF, 32'h0000_005A, rd, er, lat);
        issue(0, 0, 2'b00, 0, 32'h3FFF, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_005A || er !== 1'b0) begin
            errors++;
            $display("FAIL top_byte got %h err=%b exp 0000005a 0", rd, er);
        end
    endtask

    // Store then load to the same word with req_valid held throughout.
    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h24; wdata = 32'h0BAD_F00D;
        a_valid = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (a_rsp_valid !== 1'b1 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_store_done got vld=%b rdy=%b exp 1 1", a_rsp_valid, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 1 || a_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL b2b_load got lat=%0d rd=%h exp 1 0badf00d", n, a_rdata);
        end
    endtask

    task automatic test_wait();
        int low;
        int lat;
        @(negedge clk);
        we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h8; wdata = 32'h1122_3344;
        b_valid = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'h0;   // load to the same word, held while busy
        low = 0;
        while (!b_rsp_valid && low < 40) begin
            if (b_ready === 1'b0) low++;
            @(posedge clk); #1;
        end
        checks++;
        if (low !== 4 || b_ready !== 1'b1 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_store got busy=%0d rdy=%b err=%b exp 4 1 0", low, b_ready, b_err);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        checks++;
        if (b_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_accept got rdy=%b exp 0", b_ready);
        end
        lat = 0;
        while (!b_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || b_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL wait_load got lat=%0d rd=%h exp 4 11223344", lat, b_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        int seen;
        issue(1, 1, 2'b10, 0, 32'h20, 32'h55AA_55AA, rd, er, lat);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hDEAD_BEEF;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (b_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rdata !== 32'd0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b rd=%h err=%b exp 1 0 0 0", b_ready, b_rsp_valid, b_rdata, b_err);
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (b_rsp_valid) seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (b_rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_rsp got %0d pulses exp 0", seen);
        end
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55AA_55AA || er !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL reset_mid_mem got %h err=%b lat=%0d exp 55aa55aa 0 4", rd, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_range();
        test_back_to_back();
        test_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
